// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (640x480@60 Hz by default) from the 50 MHz
// system clock. A pixel enable toggles every Clk. The raster counters advance
// on edges where that enable is high.
// Sync and blank are decoded from the next-state counters and registered, so
// they line up with DrawX/DrawY in the same cycle.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        pix_en,
  output logic        hs,
  output logic        vs,
  output logic        blank_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_clk,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic        pix_en_q;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        x_wrap, y_wrap;

  // Next raster position, and the sync/blank decode of that position.
  always_comb begin
    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (pix_en_q) begin
      if (x_wrap) begin
        x_d = 10'd0;
        y_d = y_wrap ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hs_d          = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vs_d          = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    blank_n_d     = (x_d < H_VIS) && (y_d < V_VIS);
    // Only a real wrap from the last pixel counts; reset to (0,0) does not.
    frame_start_d = pix_en_q && x_wrap && y_wrap;
    frame_count_d = frame_count_q + {15'd0, frame_start_d};
  end

  // State registers with synchronous reset to the top-left, syncs inactive.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en_q      <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_clk   = vs_q;
  assign blank_n     = blank_n_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. One full-size instance covers reset and
// horizontal timing. A shrunken instance covers the vertical timing, frame wrap,
// counter wrap and mid-frame reset, so that it finishes in a few thousand clocks.
// Shrunken raster: H 8+2+3+3 = 16 pixels, V 4+2+2+2 = 10 lines,
// hs low for x 10..12, vs low for y 6..7, frame = 160 pixels = 320 Clks.
// After a reset release, edge k gives pixel p = k/2, x = p%16, y = (p/16)%10.
module tb_vga_timing_gen;

  logic        Clk = 1'b0;
  logic        reset_l, reset_s;

  logic        pix_en_l, hs_l, vs_l, blank_n_l, frame_clk_l, frame_start_l;
  logic [9:0]  x_l, y_l;
  logic [15:0] fc_l;

  logic        pix_en_s, hs_s, vs_s, blank_n_s, frame_clk_s, frame_start_s;
  logic [9:0]  x_s, y_s;
  logic [15:0] fc_s;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  vga_timing_gen dut (
    .Clk(Clk), .Reset(reset_l), .pix_en(pix_en_l), .hs(hs_l), .vs(vs_l),
    .blank_n(blank_n_l), .DrawX(x_l), .DrawY(y_l), .frame_clk(frame_clk_l),
    .frame_start(frame_start_l), .frame_count(fc_l)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .Clk(Clk), .Reset(reset_s), .pix_en(pix_en_s), .hs(hs_s), .vs(vs_s),
    .blank_n(blank_n_s), .DrawX(x_s), .DrawY(y_s), .frame_clk(frame_clk_s),
    .frame_start(frame_start_s), .frame_count(fc_s)
  );

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_l = 1'b1;
    reset_s = 1'b1;
    step(2);
    chk("l_rst_x", 32'(x_l), 0);
    chk("l_rst_hs", 32'(hs_l), 1);
    reset_l = 1'b0;

    // Run to an arbitrary count, then hold reset for three clocks.
    step(37);
    reset_l = 1'b1;
    step(3);
    chk("l_rst_x2", 32'(x_l), 0);
    chk("l_rst_y2", 32'(y_l), 0);
    chk("l_rst_hs2", 32'(hs_l), 1);
    chk("l_rst_vs2", 32'(vs_l), 1);
    chk("l_rst_fclk2", 32'(frame_clk_l), 1);
    chk("l_rst_blank2", 32'(blank_n_l), 1);
    chk("l_rst_fc2", 32'(fc_l), 0);
    chk("l_rst_pix2", 32'(pix_en_l), 0);
    chk("l_rst_fs2", 32'(frame_start_l), 0);
    reset_l = 1'b0;
    step(1);                                   // k=1
    chk("l_k1_pix", 32'(pix_en_l), 1);
    chk("l_k1_x", 32'(x_l), 0);
    step(1);                                   // k=2
    chk("l_k2_x", 32'(x_l), 1);
    chk("l_k2_pix", 32'(pix_en_l), 0);

    step(1276);                                // k=1278, x=639
    chk("l_x639", 32'(x_l), 639);
    chk("l_x639_blank", 32'(blank_n_l), 1);
    step(2);                                   // x=640
    chk("l_x640", 32'(x_l), 640);
    chk("l_x640_blank", 32'(blank_n_l), 0);
    chk("l_x640_hs", 32'(hs_l), 1);
    step(30);                                  // x=655
    chk("l_x655_hs", 32'(hs_l), 1);
    step(2);                                   // k=1312, x=656
    chk("l_x656", 32'(x_l), 656);
    chk("l_x656_hs", 32'(hs_l), 0);
    step(191);                                 // k=1503, x=751
    chk("l_x751", 32'(x_l), 751);
    chk("l_x751_hs", 32'(hs_l), 0);
    step(1);                                   // k=1504, x=752: 192 Clks low
    chk("l_x752", 32'(x_l), 752);
    chk("l_x752_hs", 32'(hs_l), 1);
    step(94);                                  // k=1598, x=799
    chk("l_x799", 32'(x_l), 799);
    chk("l_x799_y", 32'(y_l), 0);
    step(2);                                   // k=1600, x=0 y=1
    chk("l_wrap_x", 32'(x_l), 0);
    chk("l_wrap_y", 32'(y_l), 1);
    chk("l_wrap_blank", 32'(blank_n_l), 1);
    chk("l_wrap_fs", 32'(frame_start_l), 0);

    // Shrunken raster.
    reset_s = 1'b0;
    step(18);                                  // k=18, x=9
    chk("s_x9_hs", 32'(hs_s), 1);
    step(2);                                   // k=20, x=10
    chk("s_x10", 32'(x_s), 10);
    chk("s_x10_hs", 32'(hs_s), 0);
    step(170);                                 // k=190, x=15 y=5
    chk("s_y5_x", 32'(x_s), 15);
    chk("s_y5_y", 32'(y_s), 5);
    chk("s_y5_vs", 32'(vs_s), 1);
    step(2);                                   // k=192, x=0 y=6
    chk("s_y6_y", 32'(y_s), 6);
    chk("s_y6_vs", 32'(vs_s), 0);
    chk("s_y6_fclk", 32'(frame_clk_s), 0);
    chk("s_y6_blank", 32'(blank_n_s), 0);
    step(62);                                  // k=254, x=15 y=7
    chk("s_y7_vs", 32'(vs_s), 0);
    step(2);                                   // k=256, x=0 y=8
    chk("s_y8_y", 32'(y_s), 8);
    chk("s_y8_vs", 32'(vs_s), 1);
    chk("s_y8_fclk", 32'(frame_clk_s), 1);
    step(62);                                  // k=318, x=15 y=9
    chk("s_last_fs", 32'(frame_start_s), 0);
    chk("s_last_fc", 32'(fc_s), 0);
    step(1);                                   // k=319
    chk("s_k319_fs", 32'(frame_start_s), 0);
    step(1);                                   // k=320, frame wrap
    chk("s_wrap1_x", 32'(x_s), 0);
    chk("s_wrap1_y", 32'(y_s), 0);
    chk("s_wrap1_fs", 32'(frame_start_s), 1);
    chk("s_wrap1_fc", 32'(fc_s), 1);
    step(1);                                   // k=321
    chk("s_k321_fs", 32'(frame_start_s), 0);
    chk("s_k321_fc", 32'(fc_s), 1);
    step(319);                                 // k=640, second wrap
    chk("s_wrap2_fs", 32'(frame_start_s), 1);
    chk("s_wrap2_fc", 32'(fc_s), 2);

    step(1);                                   // k=641
    force dut_s.frame_count_q = 16'hFFFF;
    #1;
    release dut_s.frame_count_q;
    chk("s_forced_fc", 32'(fc_s), 65535);
    step(319);                                 // k=960, third wrap
    chk("s_wrap3_fs", 32'(frame_start_s), 1);
    chk("s_wrap3_fc", 32'(fc_s), 0);

    step(218);                                 // k=1178, x=13 y=6
    chk("s_mid_x", 32'(x_s), 13);
    chk("s_mid_y", 32'(y_s), 6);
    chk("s_mid_vs", 32'(vs_s), 0);
    chk("s_mid_hs", 32'(hs_s), 1);
    reset_s = 1'b1;
    step(1);
    chk("s_mrst_vs", 32'(vs_s), 1);
    chk("s_mrst_fclk", 32'(frame_clk_s), 1);
    chk("s_mrst_x", 32'(x_s), 0);
    chk("s_mrst_y", 32'(y_s), 0);
    chk("s_mrst_fc", 32'(fc_s), 0);
    chk("s_mrst_fs", 32'(frame_start_s), 0);
    chk("s_mrst_blank", 32'(blank_n_s), 1);
    chk("s_mrst_pix", 32'(pix_en_s), 0);
    reset_s = 1'b0;
    step(1);
    chk("s_post_fs", 32'(frame_start_s), 0);
    chk("s_post_pix", 32'(pix_en_s), 1);
    step(1);
    chk("s_post_x", 32'(x_s), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
